// File: rtl/bp_fe_instr_buffer_if.sv
// Handshake bundle between the fetch realigner, the instruction buffer and the
// instruction scan / FE-queue consumer. The buffer connects through the slave
// modport; the surrounding front end (or a bench) uses the master modport.
interface bp_fe_instr_buffer_if #(
  parameter int vaddr_width_p = 39,
  parameter int els_p         = 4
);

  localparam int cnt_w_lp = $clog2(els_p + 1);

  // Redirect / poison from the backend
  logic                     flush_i;

  // Producer side: realigned instructions from fetch
  logic [vaddr_width_p-1:0] fetch_instr_pc_i;
  logic [31:0]              fetch_instr_i;
  logic                     fetch_instr_v_i;
  logic                     fetch_partial_i;
  logic                     fetch_instr_yumi_o;

  // Consumer side: head entry of the buffer
  logic [vaddr_width_p-1:0] instr_pc_o;
  logic [31:0]              instr_o;
  logic                     instr_partial_o;
  logic                     instr_compressed_o;
  logic                     instr_v_o;
  logic                     instr_ready_and_i;

  // Occupancy status
  logic [cnt_w_lp-1:0]      count_o;
  logic                     empty_o;
  logic                     full_o;

  modport slave (
    input  flush_i,
    input  fetch_instr_pc_i, fetch_instr_i, fetch_instr_v_i, fetch_partial_i,
    output fetch_instr_yumi_o,
    output instr_pc_o, instr_o, instr_partial_o, instr_compressed_o, instr_v_o,
    input  instr_ready_and_i,
    output count_o, empty_o, full_o
  );

  modport master (
    output flush_i,
    output fetch_instr_pc_i, fetch_instr_i, fetch_instr_v_i, fetch_partial_i,
    input  fetch_instr_yumi_o,
    input  instr_pc_o, instr_o, instr_partial_o, instr_compressed_o, instr_v_o,
    output instr_ready_and_i,
    input  count_o, empty_o, full_o
  );

endinterface

// File: rtl/bp_fe_instr_buffer.sv
// In-order instruction FIFO sitting right after the fetch realigner.
// Each entry holds {pc, instr, partial}; the compressed tag is derived from the
// stored instruction bits at the output. A flush empties the buffer in one cycle
// by resetting pointers and count while leaving storage untouched.
// vaddr_width_p matches the default processor configuration (39-bit vaddr).
module bp_fe_instr_buffer #(
  parameter int vaddr_width_p = 39,
  parameter int els_p         = 4
) (
  input logic                clk_i,
  input logic                reset_i,
  bp_fe_instr_buffer_if.slave fe_if
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [cnt_w_lp-1:0] full_count_lp = cnt_w_lp'(els_p);
  localparam logic [ptr_w_lp-1:0] ptr_one_lp    = ptr_w_lp'(1);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp    = cnt_w_lp'(1);

  // Storage, split per field so each maps onto a plain register array
  logic [vaddr_width_p-1:0] pc_mem    [els_p];
  logic [31:0]              instr_mem [els_p];
  logic [els_p-1:0]         partial_mem;

  logic [ptr_w_lp-1:0] rptr_r;
  logic [ptr_w_lp-1:0] wptr_r;
  logic [cnt_w_lp-1:0] count_r;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  logic instr_v;

  // Occupancy flags and handshakes; full blocks enqueue regardless of a
  // same-cycle dequeue so yumi never depends on the consumer's ready
  always_comb begin
    full    = (count_r == full_count_lp);
    empty   = (count_r == '0);
    enq     = fe_if.fetch_instr_v_i & ~full & ~fe_if.flush_i & ~reset_i;
    instr_v = ~empty & ~fe_if.flush_i;
    deq     = instr_v & fe_if.instr_ready_and_i;
  end

  // Entry storage: written at the write pointer on every accepted instruction;
  // cleared only by reset, a flush leaves stale contents behind
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
      partial_mem <= '0;
    end else if (enq) begin
      pc_mem[wptr_r]      <= fe_if.fetch_instr_pc_i;
      instr_mem[wptr_r]   <= fe_if.fetch_instr_i;
      partial_mem[wptr_r] <= fe_if.fetch_partial_i;
    end
  end

  // Pointers wrap naturally since the depth is a power of two; flush wins
  // over any enqueue or dequeue in the same cycle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
    end else if (fe_if.flush_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_one_lp;
      if (deq) rptr_r <= rptr_r + ptr_one_lp;
    end
  end

  // Count tracks occupancy; simultaneous enq and deq cancel out
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (fe_if.flush_i) begin
      count_r <= '0;
    end else begin
      unique case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_one_lp;
        2'b01:   count_r <= count_r - cnt_one_lp;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry is read straight out of storage; no bypass from the input
  always_comb begin
    fe_if.instr_pc_o         = pc_mem[rptr_r];
    fe_if.instr_o            = instr_mem[rptr_r];
    fe_if.instr_partial_o    = partial_mem[rptr_r];
    fe_if.instr_compressed_o = (instr_mem[rptr_r][1:0] != 2'b11);
    fe_if.instr_v_o          = instr_v;
    fe_if.fetch_instr_yumi_o = enq;
    fe_if.count_o            = count_r;
    fe_if.empty_o            = empty;
    fe_if.full_o             = full;
  end

endmodule

// File: tb/tb_bp_fe_instr_buffer.sv
// Scoreboard bench for bp_fe_instr_buffer: a stimulus process offers
// instructions and records accepted ones in a queue; a monitor on the falling
// edge compares the DUT's head entry and status against that queue.
module tb_bp_fe_instr_buffer;

  localparam int VW  = 39;
  localparam int ELS = 4;

  typedef struct {
    logic [VW-1:0] pc;
    logic [31:0]   ins;
    bit            part;
    int            vis;
  } entry_t;

  logic clk_i;
  logic reset_i;

  bp_fe_instr_buffer_if #(.vaddr_width_p(VW), .els_p(ELS)) bus ();

  bp_fe_instr_buffer #(.vaddr_width_p(VW), .els_p(ELS)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .fe_if   (bus.slave)
  );

  int     checks   = 0;
  int     failures = 0;
  int     cycle    = 0;
  bit     mon_en   = 0;
  entry_t q[$];

  bit            pending  = 0;
  bit            cur_v    = 0;
  logic [VW-1:0] cur_pc   = '0;
  logic [31:0]   cur_ins  = '0;
  bit            cur_part = 0;
  bit            exp_yumi = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Cycle index used to decide when an accepted entry becomes visible
  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock of stimulus; the producer holds an unaccepted offer
  task automatic applyStimulus(input bit new_v, input logic [VW-1:0] pc, input logic [31:0] ins,
                               input bit part, input bit rdy, input bit fl);
    entry_t e;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    if (!pending) begin
      cur_v = new_v; cur_pc = pc; cur_ins = ins; cur_part = part;
    end
    bus.fetch_instr_v_i   = cur_v;
    bus.fetch_instr_pc_i  = cur_pc;
    bus.fetch_instr_i     = cur_ins;
    bus.fetch_partial_i   = cur_part;
    bus.instr_ready_and_i = rdy;
    bus.flush_i           = fl;
    exp_yumi = cur_v && !fl && (q.size() < ELS);
    if (exp_yumi) begin
      e.pc = cur_pc; e.ins = cur_ins; e.part = cur_part; e.vis = cycle + 1;
      q.push_back(e);
    end
    pending = cur_v && !exp_yumi;
  endtask

  task automatic randomStep(input bit fl);
    logic [31:0] ins;
    ins = $urandom;
    if ($urandom_range(0, 1) == 0) ins[1:0] = 2'b11;
    applyStimulus($urandom_range(0, 3) != 0, VW'({$urandom, $urandom}), ins,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, fl);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || pending) && n < 20) begin
      applyStimulus(0, '0, '0, 0, 1, 0);
      n++;
    end
    applyStimulus(0, '0, '0, 0, 1, 0);
    checkOutput("drain_bound", 64'(q.size()), 0);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before the next edge
  task automatic asyncReset();
    @(posedge clk_i);
    #3;
    bus.fetch_instr_v_i = 1'b1;
    reset_i = 1'b1;
    #1;
    checkOutput("rst_instr_v", 64'(bus.instr_v_o), 0);
    checkOutput("rst_yumi", 64'(bus.fetch_instr_yumi_o), 0);
    checkOutput("rst_empty", 64'(bus.empty_o), 1);
    checkOutput("rst_full", 64'(bus.full_o), 0);
    checkOutput("rst_count", 64'(bus.count_o), 0);
    checkOutput("rst_pc", 64'(bus.instr_pc_o), 0);
    checkOutput("rst_instr", 64'(bus.instr_o), 0);
    checkOutput("rst_partial", 64'(bus.instr_partial_o), 0);
    checkOutput("rst_compressed", 64'(bus.instr_compressed_o), 1);
    q.delete();
    pending = 0;
    cur_v = 0;
    bus.fetch_instr_v_i = 1'b0;
  endtask

  // Monitor: compares status every cycle and the head entry whenever one is expected
  always @(negedge clk_i) begin : monitor
    int     vis_n;
    bit     exp_v;
    entry_t h;
    if (!reset_i && mon_en) begin
      vis_n = q.size();
      if (vis_n > 0 && q[vis_n-1].vis > cycle) vis_n--;
      exp_v = (vis_n > 0) && !bus.flush_i;
      checkOutput("yumi", 64'(bus.fetch_instr_yumi_o), 64'(exp_yumi));
      checkOutput("instr_v", 64'(bus.instr_v_o), 64'(exp_v));
      checkOutput("count", 64'(bus.count_o), 64'(vis_n));
      checkOutput("empty", 64'(bus.empty_o), 64'(vis_n == 0));
      checkOutput("full", 64'(bus.full_o), 64'(vis_n == ELS));
      if (exp_v) begin
        h = q[0];
        checkOutput("head_pc", 64'(bus.instr_pc_o), 64'(h.pc));
        checkOutput("head_instr", 64'(bus.instr_o), 64'(h.ins));
        checkOutput("head_partial", 64'(bus.instr_partial_o), 64'(h.part));
        checkOutput("head_compressed", 64'(bus.instr_compressed_o), 64'(h.ins[1:0] != 2'b11));
        if (bus.instr_ready_and_i) void'(q.pop_front());
      end
      if (bus.flush_i) q.delete();
    end
  end

  initial begin
    reset_i               = 1'b1;
    bus.flush_i           = 1'b0;
    bus.fetch_instr_v_i   = 1'b0;
    bus.fetch_instr_pc_i  = '0;
    bus.fetch_instr_i     = '0;
    bus.fetch_partial_i   = 1'b0;
    bus.instr_ready_and_i = 1'b0;
    #2;
    checkOutput("init_rst_empty", 64'(bus.empty_o), 1);
    checkOutput("init_rst_compressed", 64'(bus.instr_compressed_o), 1);
    repeat (2) @(posedge clk_i);
    mon_en = 1;

    // Fill and drain: 4 accepted, 5th blocked while full
    for (int i = 0; i < 5; i++)
      applyStimulus(1, VW'(64'h8000_0000 + 4 * i), 32'h0000_0013 + 32'(i << 7), 0, 0, 0);
    checkOutput("fill_pending", 64'(pending), 1);
    drain();

    // Compressed and partial tagging
    applyStimulus(1, VW'(64'h8000_0100), 32'h0000_4501, 1, 0, 0);
    applyStimulus(1, VW'(64'h8000_0102), 32'h0000_0013, 0, 0, 0);
    drain();

    // Wrap-around streaming with ready held high
    for (int i = 0; i < 10; i++)
      applyStimulus(1, VW'(64'h8000_0200 + 4 * i), $urandom | 32'h3, 0, 1, 0);
    drain();

    // Flush collision with three entries buffered
    for (int i = 0; i < 3; i++)
      applyStimulus(1, VW'(64'h8000_0300 + 4 * i), 32'h0000_0013, 0, 0, 0);
    applyStimulus(1, VW'(64'h8000_0400), 32'h0000_0093, 1, 1, 1);
    applyStimulus(0, '0, '0, 0, 0, 0);
    drain();

    // Full with a simultaneous dequeue
    for (int i = 0; i < 4; i++)
      applyStimulus(1, VW'(64'h8000_0500 + 4 * i), 32'h0000_0013, 0, 0, 0);
    applyStimulus(1, VW'(64'h8000_0600), 32'h0000_4501, 0, 1, 0);
    applyStimulus(0, '0, '0, 0, 1, 0);
    drain();

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) randomStep($urandom_range(0, 19) == 0);

    // Mid-stream reset, then first yumi in the cycle reset falls
    asyncReset();
    applyStimulus(1, VW'(64'h8000_0700), 32'h0000_0013, 0, 0, 0);
    for (int i = 0; i < 200; i++) randomStep($urandom_range(0, 24) == 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
